// File: rtl/adc_pulse_gen_pkg.sv
// Shared constants, state encoding and arithmetic helper for the pulse generator and the filter.
// Latency: none (package only).
// Backpressure: none (package only).
package adc_pulse_gen_pkg;

    localparam int SIZE_ADC_DATA = 12;
    localparam int FRAC_BITS     = 8;
    localparam int PERIOD_W      = 16;
    localparam int ACC_W         = SIZE_ADC_DATA + FRAC_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        DECAY = 1'b1
    } state_t;

    // Unsigned add that clamps to all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/adc_pulse_gen_timer.sv
// Auto-fire period counter: emits a launch strobe on the cycle the count reaches period-1.
// Latency: fire is combinational from the registered count (same cycle).
// Backpressure: none; enable low freezes the count and suppresses fire.
module pulse_period_timer
    import adc_pulse_gen_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                auto_mode,
    input  logic [PERIOD_W-1:0] period,
    output logic                fire
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] last;
    logic                armed;

    assign last  = period - ONE;
    assign armed = auto_mode && (period != '0);

    // Launch only on an exact match; a count stranded above a shortened period wraps silently.
    always_comb begin
        fire = enable && armed && (cnt == last);
    end

    // Count up while armed, wrap at period-1 (or beyond it), clear when disarmed.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (enable) begin
            if (!armed) begin
                cnt <= '0;
            end else if (cnt >= last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + ONE;
            end
        end
    end

endmodule

// File: rtl/adc_pulse_gen.sv
// Synthetic detector pulse source: step of programmable amplitude on a baseline with exponential tail.
// Latency: a launch sampled at edge N shows on adc_data after edge N+1.
// Backpressure: none; enable low freezes every register and ignores trigger.
module adc_pulse_gen
    import adc_pulse_gen_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     trigger,
    input  logic                     auto_mode,
    input  logic [PERIOD_W-1:0]      period,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    input  logic [SIZE_ADC_DATA-1:0] baseline,
    input  logic [3:0]               decay_shift,
    output logic [SIZE_ADC_DATA-1:0] adc_data,
    output logic                     pulse_strobe,
    output logic                     busy,
    output logic                     sat_flag
);

    state_t                   state;
    logic [ACC_W-1:0]         acc;
    logic [3:0]               shift_reg;
    logic [SIZE_ADC_DATA-1:0] baseline_reg;
    logic                     launch_d;

    logic                     auto_fire;
    logic                     launch;
    logic [ACC_W-1:0]         dec_raw;
    logic [ACC_W-1:0]         dec;
    logic [ACC_W-1:0]         acc_sub;
    logic                     decays_out;
    logic [ACC_W-1:0]         acc_dec;
    logic [ACC_W-1:0]         amp_ext;
    logic [ACC_W-1:0]         acc_launch;
    logic [SIZE_ADC_DATA:0]   sum;

    pulse_period_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .auto_mode (auto_mode),
        .period    (period),
        .fire      (auto_fire)
    );

    // Trigger and auto-fire merge into one launch so coincident requests add amplitude once.
    always_comb begin
        launch = enable && (trigger || auto_fire);
    end

    // Decay step and launch value; the 1-LSB floor keeps long time constants from stalling.
    always_comb begin
        dec_raw    = acc >> shift_reg;
        dec        = (dec_raw == '0) ? ACC_W'(1) : dec_raw;
        acc_sub    = acc - dec;
        decays_out = (acc_sub[ACC_W-1:FRAC_BITS] == '0);
        acc_dec    = ((state == DECAY) && !decays_out) ? acc_sub : '0;
        amp_ext    = {amplitude, {FRAC_BITS{1'b0}}};
        acc_launch = sat_add(acc_dec, amp_ext);
        sum        = {1'b0, baseline_reg} + {1'b0, acc[ACC_W-1:FRAC_BITS]};
    end

    // Pulse FSM, accumulator and output register, all advancing only on enabled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            shift_reg    <= '0;
            baseline_reg <= '0;
            launch_d     <= 1'b0;
            adc_data     <= '0;
            pulse_strobe <= 1'b0;
            busy         <= 1'b0;
            sat_flag     <= 1'b0;
        end else if (enable) begin
            launch_d <= launch;
            if (state == IDLE) begin
                baseline_reg <= baseline;
            end
            if (launch) begin
                acc       <= acc_launch;
                shift_reg <= decay_shift;
                state     <= DECAY;
            end else if (state == DECAY) begin
                acc <= acc_dec;
                if (decays_out) begin
                    state <= IDLE;
                end
            end
            adc_data     <= sum[SIZE_ADC_DATA] ? {SIZE_ADC_DATA{1'b1}} : sum[SIZE_ADC_DATA-1:0];
            sat_flag     <= sum[SIZE_ADC_DATA] || (acc == {ACC_W{1'b1}});
            pulse_strobe <= launch_d;
            busy         <= (state == DECAY);
        end
    end

endmodule

// File: tb/tb_adc_pulse_gen.sv
// Directed bench for adc_pulse_gen with hand-computed expected samples.
// Latency: launch at edge N -> sample after edge N+1.
// Backpressure: none; enable freeze exercised explicitly.
module tb_adc_pulse_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        trigger;
    logic        auto_mode;
    logic [15:0] period;
    logic [11:0] amplitude;
    logic [11:0] baseline;
    logic [3:0]  decay_shift;
    logic [11:0] adc_data;
    logic        pulse_strobe;
    logic        busy;
    logic        sat_flag;

    int n_cmp = 0;
    int n_err = 0;

    adc_pulse_gen dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .trigger      (trigger),
        .auto_mode    (auto_mode),
        .period       (period),
        .amplitude    (amplitude),
        .baseline     (baseline),
        .decay_shift  (decay_shift),
        .adc_data     (adc_data),
        .pulse_strobe (pulse_strobe),
        .busy         (busy),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        enable = 1'b1; trigger = 1'b0; auto_mode = 1'b0; period = 16'd0;
        amplitude = 12'd0; baseline = 12'd100; decay_shift = 4'd0;
        reset = 1'b1;
        step(); step();
        n_cmp++; if (adc_data !== 12'd0) begin n_err++; $display("FAIL reset_adc: got %0d expected 0", adc_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (pulse_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %0b expected 0", pulse_strobe); end
        n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL reset_sat: got %0b expected 0", sat_flag); end
        reset = 1'b0;
    endtask

    task automatic test_idle();
        step();
        n_cmp++; if (adc_data !== 12'd0) begin n_err++; $display("FAIL idle_first: got %0d expected 0", adc_data); end
        step();
        n_cmp++; if (adc_data !== 12'd100) begin n_err++; $display("FAIL idle_base: got %0d expected 100", adc_data); end
        for (int i = 0; i < 3; i++) step();
        n_cmp++; if (adc_data !== 12'd100 || busy !== 1'b0 || pulse_strobe !== 1'b0) begin
            n_err++; $display("FAIL idle_hold: got adc=%0d busy=%0b strobe=%0b expected 100/0/0", adc_data, busy, pulse_strobe);
        end
    endtask

    task automatic test_single_pulse();
        logic [11:0] prev;
        bit ok;
        amplitude = 12'd1000; decay_shift = 4'd4; baseline = 12'd100;
        trigger = 1'b1; step(); trigger = 1'b0;
        n_cmp++; if (pulse_strobe !== 1'b0) begin n_err++; $display("FAIL single_early_strobe: got %0b expected 0", pulse_strobe); end
        step();
        n_cmp++; if (adc_data !== 12'd1100 || pulse_strobe !== 1'b1 || busy !== 1'b1) begin
            n_err++; $display("FAIL single_step: got adc=%0d strobe=%0b busy=%0b expected 1100/1/1", adc_data, pulse_strobe, busy);
        end
        step();
        n_cmp++; if (adc_data !== 12'd1037 || pulse_strobe !== 1'b0) begin
            n_err++; $display("FAIL single_tail1: got adc=%0d strobe=%0b expected 1037/0", adc_data, pulse_strobe);
        end
        step();
        n_cmp++; if (adc_data !== 12'd978) begin n_err++; $display("FAIL single_tail2: got %0d expected 978", adc_data); end
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            prev = adc_data;
            step();
            n_cmp++; if (adc_data > prev) begin n_err++; $display("FAIL single_monotonic: got %0d after %0d expected non-increasing", adc_data, prev); end
            if (!busy) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL single_settle: got busy=%0b expected 0 within 400 cycles", busy); end
        n_cmp++; if (adc_data !== 12'd100) begin n_err++; $display("FAIL single_final: got %0d expected 100", adc_data); end
    endtask

    task automatic test_pileup();
        bit ok;
        amplitude = 12'd3000; decay_shift = 4'd4; baseline = 12'd100;
        trigger = 1'b1; step(); trigger = 1'b0;
        step();
        n_cmp++; if (adc_data !== 12'd3100 || sat_flag !== 1'b0) begin
            n_err++; $display("FAIL pile_first: got adc=%0d sat=%0b expected 3100/0", adc_data, sat_flag);
        end
        trigger = 1'b1; step(); trigger = 1'b0;
        n_cmp++; if (adc_data !== 12'd2912) begin n_err++; $display("FAIL pile_decay: got %0d expected 2912", adc_data); end
        step();
        n_cmp++; if (adc_data !== 12'd4095 || sat_flag !== 1'b1 || pulse_strobe !== 1'b1) begin
            n_err++; $display("FAIL pile_clip: got adc=%0d sat=%0b strobe=%0b expected 4095/1/1", adc_data, sat_flag, pulse_strobe);
        end
        step();
        n_cmp++; if (adc_data !== 12'd3940 || sat_flag !== 1'b0) begin
            n_err++; $display("FAIL pile_resume: got adc=%0d sat=%0b expected 3940/0", adc_data, sat_flag);
        end
        wait_idle(600, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL pile_settle: got busy=%0b expected 0 within 600 cycles", busy); end
    endtask

    task automatic test_auto();
        int stamps[$];
        bit ok;
        amplitude = 12'd100; decay_shift = 4'd2; baseline = 12'd100;
        auto_mode = 1'b1; period = 16'd50;
        for (int i = 1; i <= 1010; i++) begin
            step();
            if (pulse_strobe) stamps.push_back(i);
            if (i == 1000) auto_mode = 1'b0;
        end
        n_cmp++; if (stamps.size() != 20) begin n_err++; $display("FAIL auto_count: got %0d expected 20", stamps.size()); end
        if (stamps.size() > 0) begin
            n_cmp++; if (stamps[0] != 51) begin n_err++; $display("FAIL auto_first: got cycle %0d expected 51", stamps[0]); end
        end
        for (int k = 1; k < stamps.size(); k++) begin
            n_cmp++; if (stamps[k] - stamps[k-1] != 50) begin
                n_err++; $display("FAIL auto_spacing: got %0d expected 50 at strobe %0d", stamps[k] - stamps[k-1], k);
            end
        end
        wait_idle(100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL auto_settle: got busy=%0b expected 0 within 100 cycles", busy); end
    endtask

    task automatic test_coincident();
        amplitude = 12'd500; decay_shift = 4'd0; baseline = 12'd0;
        auto_mode = 1'b1; period = 16'd10;
        for (int i = 0; i < 9; i++) step();
        trigger = 1'b1; step(); trigger = 1'b0; auto_mode = 1'b0;
        step();
        n_cmp++; if (adc_data !== 12'd500 || pulse_strobe !== 1'b1) begin
            n_err++; $display("FAIL coinc_single_add: got adc=%0d strobe=%0b expected 500/1", adc_data, pulse_strobe);
        end
        step();
        n_cmp++; if (adc_data !== 12'd0 || pulse_strobe !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL coinc_one_sample: got adc=%0d strobe=%0b busy=%0b expected 0/0/0", adc_data, pulse_strobe, busy);
        end
    endtask

    task automatic test_period_change();
        int hits;
        amplitude = 12'd500; decay_shift = 4'd0; baseline = 12'd0;
        auto_mode = 1'b1; period = 16'd20;
        for (int i = 0; i < 15; i++) step();
        period = 16'd10;
        hits = 0;
        for (int s = 1; s <= 11; s++) begin
            step();
            if (pulse_strobe) hits++;
        end
        n_cmp++; if (hits != 0) begin n_err++; $display("FAIL period_wrap_silent: got %0d strobes expected 0", hits); end
        step();
        n_cmp++; if (pulse_strobe !== 1'b1) begin n_err++; $display("FAIL period_new_fire: got %0b expected 1", pulse_strobe); end
        auto_mode = 1'b0;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_freeze();
        logic [11:0] exp_tail [4];
        bit ok;
        exp_tail = '{12'd978, 12'd923, 12'd872, 12'd824};
        amplitude = 12'd1000; decay_shift = 4'd4; baseline = 12'd100;
        step(); step();
        trigger = 1'b1; step(); trigger = 1'b0;
        step();
        n_cmp++; if (adc_data !== 12'd1100) begin n_err++; $display("FAIL freeze_step: got %0d expected 1100", adc_data); end
        step();
        n_cmp++; if (adc_data !== 12'd1037) begin n_err++; $display("FAIL freeze_pre: got %0d expected 1037", adc_data); end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            trigger = (i == 4);
            step();
            n_cmp++; if (adc_data !== 12'd1037 || busy !== 1'b1 || pulse_strobe !== 1'b0) begin
                n_err++; $display("FAIL freeze_hold: got adc=%0d busy=%0b strobe=%0b expected 1037/1/0", adc_data, busy, pulse_strobe);
            end
        end
        trigger = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (adc_data !== exp_tail[i] || pulse_strobe !== 1'b0) begin
                n_err++; $display("FAIL freeze_resume: got adc=%0d strobe=%0b expected %0d/0 at sample %0d", adc_data, pulse_strobe, exp_tail[i], i);
            end
        end
        wait_idle(400, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL freeze_settle: got busy=%0b expected 0 within 400 cycles", busy); end
    endtask

    task automatic test_long_tail();
        bit ok;
        amplitude = 12'd1000; decay_shift = 4'd12; baseline = 12'd100;
        trigger = 1'b1; step(); trigger = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b1 || adc_data !== 12'd1100) begin
            n_err++; $display("FAIL long_start: got adc=%0d busy=%0b expected 1100/1", adc_data, busy);
        end
        wait_idle(29294, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL long_terminate: got busy=%0b expected 0 within 29294 cycles", busy); end
        n_cmp++; if (adc_data !== 12'd100) begin n_err++; $display("FAIL long_final: got %0d expected 100", adc_data); end
    endtask

    task automatic test_reset_mid();
        amplitude = 12'd1000; decay_shift = 4'd4; baseline = 12'd100;
        auto_mode = 1'b1; period = 16'd50;
        trigger = 1'b1; step(); trigger = 1'b0;
        step(); step(); step();
        reset = 1'b1; step();
        n_cmp++; if (adc_data !== 12'd0 || busy !== 1'b0 || pulse_strobe !== 1'b0 || sat_flag !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_out: got adc=%0d busy=%0b strobe=%0b sat=%0b expected 0/0/0/0", adc_data, busy, pulse_strobe, sat_flag);
        end
        n_cmp++; if (dut.u_timer.cnt !== 16'd0) begin n_err++; $display("FAIL rst_mid_cnt: got %0d expected 0", dut.u_timer.cnt); end
        reset = 1'b0; auto_mode = 1'b0;
        trigger = 1'b1; step(); trigger = 1'b0;
        step();
        n_cmp++; if (adc_data !== 12'd1100 || pulse_strobe !== 1'b1) begin
            n_err++; $display("FAIL rst_cold_step: got adc=%0d strobe=%0b expected 1100/1", adc_data, pulse_strobe);
        end
        step();
        n_cmp++; if (adc_data !== 12'd1037) begin n_err++; $display("FAIL rst_cold_tail: got %0d expected 1037", adc_data); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_pulse();
        test_pileup();
        test_auto();
        test_coincident();
        test_period_change();
        test_freeze();
        test_long_tail();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc_pulse_gen.md
Name: adc_pulse_gen

Overview:
- Synthesizes ADC-like detector pulses for the shaping-filter chain: a step of programmable amplitude on a baseline, followed by an exponential tail.
- Drives the filter's `input_data` in place of the real ADC, for closed-loop test and for calibration of the filter's decay-compensation constant.
- Supports single triggers, periodic auto-firing and pile-up, so the filter can be exercised under realistic rates.

Parameters:
- SIZE_ADC_DATA, 12, output sample width; shared package constant, same value as the filter input.
- FRAC_BITS, 8, fractional bits of the decay accumulator.
- PERIOD_W, 16, width of the auto-fire period counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  advance generator; low freezes all state
- trigger  in  1  single-cycle launch request
- auto_mode  in  1  periodic launch enable
- period  in  PERIOD_W  auto-fire period in cycles; 0 disables auto launches
- amplitude  in  SIZE_ADC_DATA  pulse height in ADC LSB
- baseline  in  SIZE_ADC_DATA  pedestal level
- decay_shift  in  4  tail time constant, tau ~ 2^decay_shift cycles
- adc_data  out  SIZE_ADC_DATA  generated sample, one per clk
- pulse_strobe  out  1  high one cycle when a launched step first appears on adc_data
- busy  out  1  state == DECAY
- sat_flag  out  1  current adc_data is clipped

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset values: adc_data=0, pulse_strobe=0, busy=0, sat_flag=0; acc=0, state=IDLE, period counter=0, baseline_reg=0, shift_reg=0.
- acc format: unsigned, SIZE_ADC_DATA+FRAC_BITS bits. Integer part is acc[top:FRAC_BITS].
- Freeze: when enable=0, nothing changes: acc, state, counter and the output registers hold; trigger is ignored.
- Launch event, enable=1: trigger=1, or (auto_mode=1 && period!=0 && cnt==period-1).
  - A simultaneous trigger and auto launch counts as one launch and adds amplitude once.
- Launch at edge N:
  - acc <= sat(acc_next + (amplitude << FRAC_BITS)), where acc_next is this cycle's decayed value (0 in IDLE).
  - shift_reg <= decay_shift.
  - state <= DECAY.
- Pile-up: a launch while in DECAY adds to the decayed acc. Saturation clamps acc to all-ones.
- DECAY, each enabled cycle without launch:
  - dec = acc >> shift_reg, forced to a minimum of 1 LSB. The minimum guarantees termination when shift_reg > FRAC_BITS.
  - acc <= acc - dec.
  - If the new integer part would be 0: acc <= 0 and state <= IDLE.
  - shift_reg=0: acc clears on the next cycle, giving a one-sample pulse.
- baseline_reg:
  - Loaded from baseline every enabled cycle while IDLE.
  - Held while DECAY, so a pulse's pedestal is stable.
- Output register, one cycle after the acc update:
  - sum = baseline_reg + acc_int, one bit wider than the output.
  - adc_data <= min(sum, 2^SIZE_ADC_DATA-1).
  - sat_flag <= (sum overflowed) OR (acc saturated).
  - pulse_strobe <= launch occurred at the previous edge.
  - busy <= state.
- Latency: a launch sampled at edge N shows the step on adc_data after edge N+1.
- Auto counter:
  - Counts while enable && auto_mode && period!=0; wraps to 0 at period-1 (that cycle is a launch).
  - Clears to 0 when auto_mode=0 or period==0.
  - Does not reset on manual triggers.
- Reset mid-pulse: all state goes to reset values on the next edge. No residual tail.
- period changed while counting: if cnt is already >= new period-1, the counter wraps at the next cycle, with no launch from that wrap.

Decomposition:
- Package (shared with filter): SIZE_ADC_DATA, FRAC_BITS, state enum {IDLE, DECAY}, saturating-add function.
- One sub-module: pulse_period_timer (auto-fire counter, launch strobe, clear/wrap rules).
- Decay step, launch logic and output register stay in adc_pulse_gen.

Test Plan:
- Idle baseline: reset, baseline=100, no trigger -> adc_data=100 from the 2nd cycle after reset release; busy=0, pulse_strobe=0.
- Single pulse: amplitude=1000, decay_shift=4, baseline=100, one trigger -> after 2 edges adc_data=1100 with pulse_strobe=1 for one cycle.
  - Following samples are 1037, 978, … (ints of 937.5, 878.9 plus baseline), strictly non-increasing.
  - Settles to 100 with busy falling.
- Pile-up/saturation: amplitude=3000, decay_shift=4, triggers 2 cycles apart -> second step clips adc_data at 4095 with sat_flag=1.
  - Decay then resumes from acc=all-ones; sat_flag clears once sum<4096.
- Auto mode: period=50, enable for 1000 cycles -> exactly 20 pulse_strobes spaced 50 cycles apart.
  - A trigger coincident with an auto launch gives one strobe and a single amplitude add.
- Freeze and long tail:
  - enable=0 for 10 cycles mid-decay -> adc_data constant; the sequence resumes identical, shifted 10 cycles.
  - decay_shift=12 -> pulse terminates; busy falls within 2^12·ln(amplitude)+amplitude cycles.
- Reset mid-decay: reset high 1 cycle during tail -> adc_data=0, busy=0, counter=0 after that edge; next trigger behaves as from cold.
